// File: rtl/tlb_unit_pkg.sv
// rtl/tlb_unit_pkg.sv - TLB constants, entry layout and EntryLo pack/unpack helpers
package tlb_unit_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int TLB_IDX_W   = 4;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  // Index register image for a probe miss: P bit set, idx field zero
  localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

  typedef logic [TLB_IDX_W-1:0] tlb_idx_t;

  // One page of an entry, laid out exactly like EntryLo[25:1]
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic        valid;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  // Takes EntryLo[25:1]; G is handled separately because it is shared by both pages
  function automatic tlb_page_t lo_to_page(input logic [24:0] lo_bits);
    return tlb_page_t'(lo_bits);
  endfunction

  function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
    return {6'b0, p, g};
  endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - 16-way tag compare with lowest-index-wins priority encode
module tlb_match
  import tlb_unit_pkg::*;
(
  input  logic [TLB_ENTRIES-1:0]       valid,
  input  logic [TLB_ENTRIES-1:0]       g,
  input  logic [TLB_ENTRIES-1:0][18:0] vpn2,
  input  logic [TLB_ENTRIES-1:0][7:0]  asid,
  input  logic [18:0]                  q_vpn2,
  input  logic [7:0]                   q_asid,
  output logic                         hit,
  output tlb_idx_t                     idx
);

  // Scan from the top down so the lowest matching index is the one that sticks
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (vpn2[i] == q_vpn2) && (g[i] || (asid[i] == q_asid))) begin
        hit = 1'b1;
        idx = tlb_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 16-entry MIPS-style TLB with inst/data translation and tlbp/tlbr/tlbwi
module tlb_unit
  import tlb_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_tlbp,
  input  logic        op_tlbr,
  input  logic        op_tlbwi,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  output logic [31:0] tlb_index,
  output logic [31:0] tlb_entryhi,
  output logic [31:0] tlb_entrylo0,
  output logic [31:0] tlb_entrylo1,
  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic [31:0] inst_paddr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_vaddr,
  output logic [31:0] data_paddr,
  output logic        i_refill,
  output logic        i_invalid,
  output logic        d_refill,
  output logic        d_invalid,
  output logic        d_modify
);

  // Kept in flops so reset can wipe every entry at once
  tlb_entry_t [TLB_ENTRIES-1:0] ents;

  logic [TLB_ENTRIES-1:0]       e_valid;
  logic [TLB_ENTRIES-1:0]       e_g;
  logic [TLB_ENTRIES-1:0][18:0] e_vpn2;
  logic [TLB_ENTRIES-1:0][7:0]  e_asid;

  tlb_idx_t   op_idx;
  tlb_entry_t new_ent;

  logic     i_mapped, i_hit, i_v;
  logic     d_mapped, d_hit, d_v, d_d;
  logic     p_hit;
  tlb_idx_t i_idx, d_idx, p_idx;
  logic [19:0] i_pfn, d_pfn;

  // Fields the CP0 operations never look at
  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:TLB_IDX_W], cp0_entryhi[12:8],
                         cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign op_idx  = cp0_index[TLB_IDX_W-1:0];
  assign new_ent = '{valid: 1'b1,
                     vpn2:  cp0_entryhi[31:13],
                     asid:  cp0_entryhi[7:0],
                     g:     cp0_entrylo0[0] & cp0_entrylo1[0],
                     p0:    lo_to_page(cp0_entrylo0[25:1]),
                     p1:    lo_to_page(cp0_entrylo1[25:1])};

  // Flatten the tag fields the three matchers compare against
  always_comb begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      e_valid[i] = ents[i].valid;
      e_g[i]     = ents[i].g;
      e_vpn2[i]  = ents[i].vpn2;
      e_asid[i]  = ents[i].asid;
    end
  end

  tlb_match u_inst_match (
    .valid (e_valid), .g (e_g), .vpn2 (e_vpn2), .asid (e_asid),
    .q_vpn2 (inst_vaddr[31:13]), .q_asid (cp0_entryhi[7:0]),
    .hit (i_hit), .idx (i_idx)
  );

  tlb_match u_data_match (
    .valid (e_valid), .g (e_g), .vpn2 (e_vpn2), .asid (e_asid),
    .q_vpn2 (data_vaddr[31:13]), .q_asid (cp0_entryhi[7:0]),
    .hit (d_hit), .idx (d_idx)
  );

  tlb_match u_probe_match (
    .valid (e_valid), .g (e_g), .vpn2 (e_vpn2), .asid (e_asid),
    .q_vpn2 (cp0_entryhi[31:13]), .q_asid (cp0_entryhi[7:0]),
    .hit (p_hit), .idx (p_idx)
  );

  // Instruction side: kseg0/kseg1 bypass the TLB, va[12] picks the odd page
  assign i_mapped   = (inst_vaddr[31:30] != 2'b10);
  assign i_pfn      = inst_vaddr[12] ? ents[i_idx].p1.pfn : ents[i_idx].p0.pfn;
  assign i_v        = inst_vaddr[12] ? ents[i_idx].p1.v   : ents[i_idx].p0.v;
  assign inst_paddr = !i_mapped ? {3'b000, inst_vaddr[28:0]} :
                      i_hit     ? {i_pfn, inst_vaddr[11:0]}  : ZERO_WORD;
  assign i_refill   = inst_req & i_mapped & ~i_hit;
  assign i_invalid  = inst_req & i_mapped & i_hit & ~i_v;

  // Data side adds the dirty check for stores
  assign d_mapped   = (data_vaddr[31:30] != 2'b10);
  assign d_pfn      = data_vaddr[12] ? ents[d_idx].p1.pfn : ents[d_idx].p0.pfn;
  assign d_v        = data_vaddr[12] ? ents[d_idx].p1.v   : ents[d_idx].p0.v;
  assign d_d        = data_vaddr[12] ? ents[d_idx].p1.d   : ents[d_idx].p0.d;
  assign data_paddr = !d_mapped ? {3'b000, data_vaddr[28:0]} :
                      d_hit     ? {d_pfn, data_vaddr[11:0]}  : ZERO_WORD;
  assign d_refill   = data_req & d_mapped & ~d_hit;
  assign d_invalid  = data_req & d_mapped & d_hit & ~d_v;
  assign d_modify   = data_req & data_we & d_mapped & d_hit & d_v & ~d_d;

  // tlbwi: entry write; reset wins over an in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ents <= '0;
    end else if (op_tlbwi) begin
      ents[op_idx] <= new_ent;
    end
  end

  // tlbr/tlbp result registers; a concurrent tlbwi suppresses both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlb_index    <= ZERO_WORD;
      tlb_entryhi  <= ZERO_WORD;
      tlb_entrylo0 <= ZERO_WORD;
      tlb_entrylo1 <= ZERO_WORD;
    end else if (!op_tlbwi) begin
      if (op_tlbr) begin
        tlb_entryhi  <= {ents[op_idx].vpn2, 5'b0, ents[op_idx].asid};
        tlb_entrylo0 <= page_to_lo(ents[op_idx].p0, ents[op_idx].g);
        tlb_entrylo1 <= page_to_lo(ents[op_idx].p1, ents[op_idx].g);
      end else if (op_tlbp) begin
        tlb_index <= p_hit ? {{(32-TLB_IDX_W){1'b0}}, p_idx} : PROBE_MISS;
      end
    end
  end

endmodule

// File: tb/tb_tlb_unit.sv
// tb/tb_tlb_unit.sv - self-checking bench for tlb_unit against a register-image model
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_tlbp, op_tlbr, op_tlbwi;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [31:0] tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
  logic        inst_req, data_req, data_we;
  logic [31:0] inst_vaddr, inst_paddr, data_vaddr, data_paddr;
  logic        i_refill, i_invalid, d_refill, d_invalid, d_modify;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  tlb_unit dut (
    .clk (clk), .rst (rst),
    .op_tlbp (op_tlbp), .op_tlbr (op_tlbr), .op_tlbwi (op_tlbwi),
    .cp0_index (cp0_index), .cp0_entryhi (cp0_entryhi),
    .cp0_entrylo0 (cp0_entrylo0), .cp0_entrylo1 (cp0_entrylo1),
    .tlb_index (tlb_index), .tlb_entryhi (tlb_entryhi),
    .tlb_entrylo0 (tlb_entrylo0), .tlb_entrylo1 (tlb_entrylo1),
    .inst_req (inst_req), .inst_vaddr (inst_vaddr), .inst_paddr (inst_paddr),
    .data_req (data_req), .data_we (data_we), .data_vaddr (data_vaddr),
    .data_paddr (data_paddr),
    .i_refill (i_refill), .i_invalid (i_invalid),
    .d_refill (d_refill), .d_invalid (d_invalid), .d_modify (d_modify)
  );

  always #5 clk = ~clk;

  // Model: each entry is just the raw CP0 words it was written with
  bit          m_valid [16];
  logic [31:0] m_hi [16];
  logic [31:0] m_lo0 [16];
  logic [31:0] m_lo1 [16];
  logic [31:0] m_index, m_ehi, m_elo0, m_elo1;

  function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_hi[i][31:13] == vpn2 &&
          ((m_lo0[i][0] & m_lo1[i][0]) || m_hi[i][7:0] == asid))
        return i;
    return -1;
  endfunction

  function automatic void xlate(input logic req, input logic we, input logic [31:0] va,
                                input logic [7:0] asid, output logic [31:0] pa,
                                output logic rf, output logic inv, output logic md);
    int f;
    logic [31:0] lo;
    rf = 1'b0; inv = 1'b0; md = 1'b0;
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
      return;
    end
    f = m_find(va[31:13], asid);
    if (f < 0) begin
      pa = 32'h0;
      rf = req;
      return;
    end
    lo  = va[12] ? m_lo1[f] : m_lo0[f];
    pa  = {lo[25:6], va[11:0]};
    inv = req & ~lo[1];
    md  = req & we & lo[1] & ~lo[2];
  endfunction

  always @(posedge clk or posedge rst) begin
    int k, f;
    logic g;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
      end
      m_index = '0; m_ehi = '0; m_elo0 = '0; m_elo1 = '0;
    end else if (op_tlbwi) begin
      k = int'(cp0_index[3:0]);
      m_valid[k] = 1'b1;
      m_hi[k] = cp0_entryhi; m_lo0[k] = cp0_entrylo0; m_lo1[k] = cp0_entrylo1;
    end else if (op_tlbr) begin
      k = int'(cp0_index[3:0]);
      g = m_lo0[k][0] & m_lo1[k][0];
      m_ehi  = {m_hi[k][31:13], 5'b0, m_hi[k][7:0]};
      m_elo0 = {6'b0, m_lo0[k][25:1], g};
      m_elo1 = {6'b0, m_lo1[k][25:1], g};
    end else if (op_tlbp) begin
      f = m_find(cp0_entryhi[31:13], cp0_entryhi[7:0]);
      m_index = (f < 0) ? 32'h8000_0000 : f;
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] pa;
    logic rf, inv, md;
    if (check_en) begin
      xlate(inst_req, 1'b0, inst_vaddr, cp0_entryhi[7:0], pa, rf, inv, md);
      chk32("inst_paddr", inst_paddr, pa);
      chk1("i_refill", i_refill, rf);
      chk1("i_invalid", i_invalid, inv);
      xlate(data_req, data_we, data_vaddr, cp0_entryhi[7:0], pa, rf, inv, md);
      chk32("data_paddr", data_paddr, pa);
      chk1("d_refill", d_refill, rf);
      chk1("d_invalid", d_invalid, inv);
      chk1("d_modify", d_modify, md);
      chk32("tlb_index", tlb_index, m_index);
      chk32("tlb_entryhi", tlb_entryhi, m_ehi);
      chk32("tlb_entrylo0", tlb_entrylo0, m_elo0);
      chk32("tlb_entrylo1", tlb_entrylo1, m_elo1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_cp0(input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
    cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
  endtask

  initial begin
    rst = 1'b1;
    op_tlbp = 1'b0; op_tlbr = 1'b0; op_tlbwi = 1'b0;
    set_cp0(32'h0, 32'h0, 32'h0, 32'h0);
    inst_req = 1'b0; inst_vaddr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_vaddr = 32'h0;

    tick();
    check_en = 1'b1;
    tick();
    settle();
    chk32("rst_index", tlb_index, 32'h0);
    chk32("rst_entryhi", tlb_entryhi, 32'h0);
    chk32("rst_entrylo0", tlb_entrylo0, 32'h0);

    tick(); rst = 1'b0; inst_req = 1'b1; inst_vaddr = 32'h0040_0000;
    settle();
    chk1("refill_after_rst", i_refill, 1'b1);
    chk32("miss_paddr", inst_paddr, 32'h0);

    tick(); inst_vaddr = 32'hBFC0_0000;
    settle();
    chk32("unmapped_paddr", inst_paddr, 32'h1FC0_0000);
    chk1("unmapped_no_refill", i_refill, 1'b0);

    tick();
    set_cp0(32'd3, 32'h0040_0001, 32'h0000_1006, 32'h0);
    op_tlbwi = 1'b1; data_req = 1'b1; data_vaddr = 32'h0040_0123;
    settle();
    chk1("same_cycle_old_entry", d_refill, 1'b1);

    tick(); op_tlbwi = 1'b0;
    settle();
    chk32("hit_paddr", data_paddr, 32'h0004_0123);
    chk1("hit_no_refill", d_refill, 1'b0);
    chk1("hit_no_invalid", d_invalid, 1'b0);

    tick(); data_vaddr = 32'h0040_1000;
    settle();
    chk1("odd_page_invalid", d_invalid, 1'b1);

    tick(); cp0_entryhi = 32'h0040_0002; data_vaddr = 32'h0040_0123;
    settle();
    chk1("asid_mismatch_refill", d_refill, 1'b1);

    tick(); cp0_entryhi = 32'h0040_0001; op_tlbp = 1'b1;
    tick(); op_tlbp = 1'b0;
    settle();
    chk32("probe_hit", tlb_index, 32'h0000_0003);

    tick(); cp0_entryhi = 32'h0080_0001; op_tlbp = 1'b1;
    tick(); op_tlbp = 1'b0;
    settle();
    chk32("probe_miss", tlb_index, 32'h8000_0000);

    tick(); cp0_entryhi = 32'h0040_0001; cp0_index = 32'd3; op_tlbr = 1'b1;
    tick(); op_tlbr = 1'b0;
    settle();
    chk32("read_hi", tlb_entryhi, 32'h0040_0001);
    chk32("read_lo0", tlb_entrylo0, 32'h0000_1006);
    chk32("read_lo1", tlb_entrylo1, 32'h0);
    chk32("read_holds_index", tlb_index, 32'h8000_0000);

    tick();
    set_cp0(32'd5, 32'h0080_0001, 32'h0000_2002, 32'h0000_0003);
    op_tlbwi = 1'b1;
    tick(); op_tlbwi = 1'b0; data_we = 1'b1; data_vaddr = 32'h0080_0010;
    settle();
    chk1("store_clean_modify", d_modify, 1'b1);
    chk32("store_clean_paddr", data_paddr, 32'h0008_0010);

    tick(); data_we = 1'b0;
    settle();
    chk1("load_clean_no_modify", d_modify, 1'b0);

    tick();
    set_cp0(32'd7, 32'h0100_0001, 32'h0000_3007, 32'h0000_0001);
    op_tlbwi = 1'b1; op_tlbr = 1'b1;
    tick(); op_tlbwi = 1'b0;
    settle();
    chk32("wi_beats_r_holds_hi", tlb_entryhi, 32'h0040_0001);

    tick(); op_tlbr = 1'b0;
    settle();
    chk32("read_after_write_hi", tlb_entryhi, 32'h0100_0001);
    chk32("read_after_write_lo0", tlb_entrylo0, 32'h0000_3007);
    chk32("read_after_write_lo1", tlb_entrylo1, 32'h0000_0001);

    tick(); cp0_entryhi = 32'h0000_0002; data_vaddr = 32'h0100_0ABC;
    settle();
    chk32("global_hit_paddr", data_paddr, 32'h000C_0ABC);

    tick();
    set_cp0(32'd2, 32'h0100_0005, 32'h0000_5007, 32'h0000_0001);
    op_tlbwi = 1'b1;
    tick(); op_tlbwi = 1'b0; op_tlbp = 1'b1;
    settle();
    chk32("multi_hit_lowest", data_paddr, 32'h0014_0ABC);
    tick(); op_tlbp = 1'b0;
    settle();
    chk32("probe_multi_hit", tlb_index, 32'h0000_0002);

    tick(); cp0_index = 32'd12; op_tlbr = 1'b1;
    tick(); op_tlbr = 1'b0;
    settle();
    chk32("unwritten_hi", tlb_entryhi, 32'h0);
    chk32("unwritten_lo0", tlb_entrylo0, 32'h0);

    tick();
    set_cp0(32'd9, 32'h0200_0001, 32'h0000_1006, 32'h0000_0002);
    op_tlbwi = 1'b1; rst = 1'b1;
    tick(); op_tlbwi = 1'b0;
    tick(); rst = 1'b0; data_vaddr = 32'h0200_0000; inst_vaddr = 32'h0040_0000;
    settle();
    chk1("rst_discards_write", d_refill, 1'b1);
    chk1("rst_clears_entries", i_refill, 1'b1);

    tick(); op_tlbr = 1'b1;
    tick(); op_tlbr = 1'b0;
    settle();
    chk32("rst_entry_reads_zero", tlb_entrylo0, 32'h0);

    tick();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb_unit.md
TLB_UNIT -- requirements
Module: tlb_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: op_tlbp, op_tlbr, op_tlbwi  in  1 each  TLB instruction strobes from the CP0 relay.
REQ-003 SHALL have ports: cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1  in  32 each  CP0 register values for the operation.
REQ-004 SHALL have ports: tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1  out  32 each  registered operation results.
REQ-005 SHALL have ports: inst_req  in  1; inst_vaddr  in  32; inst_paddr  out  32.
REQ-006 SHALL have ports: data_req  in  1; data_we  in  1; data_vaddr  in  32; data_paddr  out  32.
REQ-007 SHALL have ports: i_refill, i_invalid, d_refill, d_invalid, d_modify  out  1 each  translation exception flags.

Function
REQ-008 SHALL hold 16 entries; each entry: valid, VPN2[18:0], ASID[7:0], G, and per page {PFN[19:0], C[2:0], D, V}.
REQ-009 Field map: EntryHi VPN2=[31:13], ASID=[7:0]; EntryLo PFN=[25:6], C=[5:3], D=[2], V=[1], G=[0]; Index P=[31], idx=[3:0].
REQ-010 SHALL define entry match as valid & VPN2==va[31:13] & (G | ASID==cp0_entryhi[7:0]); on multiple hits, the lowest index wins; va[12] selects the odd page (1) or even page (0).
REQ-011 SHALL treat va[31:30]==2'b10 (kseg0/kseg1) as unmapped: paddr={3'b000, va[28:0]}, no exception flags.
REQ-012 For mapped addresses: paddr={PFN, va[11:0]} on hit, 32'h0 on miss; translation SHALL be combinational (same cycle as vaddr).
REQ-013 i_refill = inst_req & mapped & miss; i_invalid = inst_req & mapped & hit & ~V; both combinational.
REQ-014 d_refill and d_invalid SHALL follow the same rules as REQ-013 on the data port; d_modify = data_req & data_we & mapped & hit & V & ~D.
REQ-015 At most one of the i_* flags and at most one of the d_* flags SHALL be high in any cycle.
REQ-016 tlbwi SHALL write entry cp0_index[3:0] at the clock edge: valid=1, G=lo0.G & lo1.G, other fields from EntryHi/EntryLo0/EntryLo1.
REQ-017 Lookups in the same cycle as a tlbwi SHALL see the old entry contents; the new contents are visible from the next cycle.
REQ-018 tlbp SHALL search with cp0_entryhi.
  - Result is registered; latency 1 cycle.
  - On hit: tlb_index={28'h0, idx}.
  - On miss: tlb_index=32'h8000_0000.
  - tlb_entryhi and tlb_entrylo* are held.
REQ-019 tlbr SHALL read entry cp0_index[3:0]; latency 1 cycle.
  - tlb_entryhi={VPN2, 5'b0, ASID}.
  - tlb_entryloN={6'b0, PFN, C, D, V, G}.
  - tlb_index is held.
  - A never-written entry reads all zero.
REQ-020 Result registers SHALL hold their values until the next tlbp or tlbr.
REQ-021 If more than one op strobe is high in a cycle, priority SHALL be tlbwi > tlbr > tlbp; only the winning op executes.
REQ-022 A tlbr of the same index in the cycle after a tlbwi SHALL return the written data.

Reset
REQ-023 rst SHALL be asynchronous: it clears all entry valid bits and all entry fields to 0, and sets tlb_index, tlb_entryhi, tlb_entrylo0 and tlb_entrylo1 to 32'h0.
REQ-024 If rst is asserted while an operation is in flight, the operation SHALL be discarded with no entry write and no result update.
REQ-025 After reset, every mapped access SHALL report refill.

Structure
REQ-026 Constants SHALL live in lib/defines.vh: TLB entry count (16), index width (4), EntryHi/EntryLo/Index field positions, ZeroWord.
REQ-027 One sub-module, tlb_match, SHALL be used: a 16-way compare plus priority encoder giving hit and idx; it is instantiated three times (inst, data, probe).
REQ-028 The entry array SHALL be flops, not RAM macros, so that it supports the asynchronous reset.

Verification
REQ-029 Reset, then inst_req=1 with inst_vaddr=32'h0040_0000 -> i_refill=1, inst_paddr=32'h0.
REQ-030 Unmapped translation: inst_vaddr=32'hBFC0_0000 -> inst_paddr=32'h1FC0_0000, no flags.
REQ-031 Write then use an entry:
  - Stimulus: tlbwi with index=3, entryhi=32'h0040_0001, lo0=32'h0000_1006 (PFN 0x40, D=1, V=1, G=0), lo1=32'h0.
  - Next cycle, ASID 1, data_vaddr=32'h0040_0123 -> data_paddr=32'h0004_0123, no flags.
  - data_vaddr=32'h0040_1000 -> d_invalid=1.
  - ASID 2 -> d_refill=1.
REQ-032 With lo0 D=0, data_req=1, data_we=1 on a hitting valid page -> d_modify=1; with data_we=0 -> no flag.
REQ-033 Probe and read back:
  - tlbp with entryhi=32'h0040_0001 after REQ-031 -> tlb_index=32'h0000_0003 one cycle later.
  - tlbp with entryhi=32'h0080_0001 -> tlb_index=32'h8000_0000.
  - tlbr with index=3 -> tlb_entryhi=32'h0040_0001, tlb_entrylo0=32'h0000_1006.
REQ-034 Simultaneous ops and mid-operation reset:
  - op_tlbwi and op_tlbr both high -> only the write occurs and result registers are unchanged.
  - rst asserted during tlbwi -> entry stays invalid.
